// File: rtl/miner_pkg.sv
// Widths and small helpers shared by the miner result path.
package miner_pkg;

  localparam int unsigned GOLDEN_NONCE_WIDTH = 32;
  localparam int unsigned DROP_CNT_WIDTH     = 16;

  typedef logic [GOLDEN_NONCE_WIDTH-1:0] nonce_t;
  typedef logic [DROP_CNT_WIDTH-1:0]     drop_cnt_t;

  // Saturating increment: the drop counter sticks at all-ones rather than wrapping.
  function automatic drop_cnt_t drop_cnt_inc(input drop_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/golden_nonce_queue_if.sv
// Finder-to-host result bus: golden-nonce capture inputs and the tagged valid/ready output stream.
interface golden_nonce_queue_if
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned WORK_ID_WIDTH = 4
);

  logic                     rx_found;
  nonce_t                   rx_nonce;
  logic                     rx_new_work;
  logic                     rx_clear_overflow;
  logic                     tx_valid;
  logic                     tx_ready;
  nonce_t                   tx_nonce;
  logic [WORK_ID_WIDTH-1:0] tx_work_id;
  logic [DEPTH_LOG2:0]      tx_count;
  logic                     tx_overflow;
  drop_cnt_t                tx_dropped;

  // The queue is the master: it sources the tx stream.
  modport master (
    input  rx_found, rx_nonce, rx_new_work, rx_clear_overflow, tx_ready,
    output tx_valid, tx_nonce, tx_work_id, tx_count, tx_overflow, tx_dropped
  );

  modport slave (
    output rx_found, rx_nonce, rx_new_work, rx_clear_overflow, tx_ready,
    input  tx_valid, tx_nonce, tx_work_id, tx_count, tx_overflow, tx_dropped
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count and flush.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  push_ok_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_base, wptr_base;
  logic [DEPTH_LOG2:0]   count_q, count_d, count_base;
  logic                  do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == DepthCnt);
    // A flush discards everything first, so a same-cycle pop has nothing to remove
    // and a same-cycle push always lands in the freshly emptied slot 0.
    do_pop  = pop_i & ~empty_o & ~flush_i;
    do_push = push_i & (~full_o | do_pop | flush_i);

    rptr_base  = flush_i ? '0 : rptr_q;
    wptr_base  = flush_i ? '0 : wptr_q;
    count_base = flush_i ? '0 : count_q;

    rptr_d  = rptr_base + DEPTH_LOG2'(do_pop);
    wptr_d  = wptr_base + DEPTH_LOG2'(do_push);
    count_d = count_base + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);

    push_ok_o = do_push;
    count_o   = count_q;
    rdata_o   = empty_o ? '0 : mem_q[rptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wptr_base] <= wdata_i;
    end
  end

endmodule

// File: rtl/golden_nonce_queue.sv
// Tags golden-nonce finds with the current work ID and queues them for the host,
// counting finds that arrive while the queue is full.
module golden_nonce_queue
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned WORK_ID_WIDTH = 4,
  parameter bit          FLUSH_ON_WORK = 1'b0
) (
  input logic                  hash_clk,
  input logic                  reset,
  golden_nonce_queue_if.master bus
);

  typedef struct packed {
    logic [WORK_ID_WIDTH-1:0] work_id;
    nonce_t                   nonce;
  } entry_t;

  logic [WORK_ID_WIDTH-1:0] work_id_q, work_id_d;
  logic                     overflow_q, overflow_d;
  drop_cnt_t                dropped_q, dropped_d;

  entry_t              wr_entry, head;
  logic                flush, pop, push_ok, drop;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  always_comb begin
    flush    = FLUSH_ON_WORK & bus.rx_new_work;
    pop      = ~fifo_empty & bus.tx_ready;
    // Finds are tagged with the ID in force before any same-cycle new-work increment.
    wr_entry = '{work_id: work_id_q, nonce: bus.rx_nonce};
    drop     = bus.rx_found & ~push_ok;
  end

  sync_fifo_fwft #(
    .WIDTH      ($bits(entry_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (hash_clk),
    .rst_i     (reset),
    .flush_i   (flush),
    .push_i    (bus.rx_found),
    .pop_i     (pop),
    .wdata_i   (wr_entry),
    .rdata_o   (head),
    .push_ok_o (push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    work_id_d  = work_id_q + WORK_ID_WIDTH'(bus.rx_new_work);
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (bus.rx_clear_overflow) begin
      overflow_d = 1'b0;
      dropped_d  = '0;
    end
    // A drop in the clearing cycle is counted against the freshly cleared state.
    if (drop) begin
      overflow_d = 1'b1;
      dropped_d  = drop_cnt_inc(dropped_d);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      work_id_q  <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      work_id_q  <= work_id_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  always_comb begin
    bus.tx_valid    = ~fifo_empty;
    bus.tx_nonce    = head.nonce;
    bus.tx_work_id  = head.work_id;
    bus.tx_count    = fifo_count;
    bus.tx_overflow = overflow_q;
    bus.tx_dropped  = dropped_q;
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/golden_nonce_queue.md
Name: golden_nonce_queue

Overview:
Sits directly downstream of the mining top-level's golden-ticket detector. Captures each golden-nonce event as a one-cycle pulse plus a 32-bit nonce, and tags it with the current work ID. Buffers the tagged results in a small FIFO and presents them to the host-side reporting logic over a valid/ready interface, so that back-to-back finds are never lost by register overwrite. Reports overflow with a sticky flag and a saturating drop counter.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (depth = 2^DEPTH_LOG2 entries); valid range 1..6
WORK_ID_WIDTH, 4, width of the work tag attached to each entry
FLUSH_ON_WORK, 0, 1 = rx_new_work discards all queued entries; 0 = queued entries are kept with their old tags

Ports:
hash_clk  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_found  in  1  one-cycle pulse: rx_nonce holds a golden nonce
rx_nonce  in  32  golden nonce value, sampled when rx_found=1
rx_new_work  in  1  one-cycle pulse: new midstate/data loaded into the hashers
rx_clear_overflow  in  1  pulse: clears tx_overflow and tx_dropped
tx_valid  out  1  head entry available
tx_ready  in  1  consumer accepts head entry when tx_valid & tx_ready
tx_nonce  out  32  head entry nonce
tx_work_id  out  WORK_ID_WIDTH  head entry work tag
tx_count  out  DEPTH_LOG2+1  number of entries queued, including the head
tx_overflow  out  1  sticky: at least one find dropped
tx_dropped  out  16  count of dropped finds, saturating at 16'hFFFF

Behaviour:
- Reset (synchronous, reset=1 at the edge): tx_valid=0, tx_nonce=0, tx_work_id=0, tx_count=0, tx_overflow=0, tx_dropped=0, internal work ID=0, read/write pointers=0. Reset overrides every other input in the same cycle. A reset during a pending handshake discards all entries.
- Work ID: 
  - Increments by 1 modulo 2^WORK_ID_WIDTH on each rx_new_work pulse.
  - An rx_found in the same cycle as rx_new_work is tagged with the pre-increment ID.
  - Host resolves pipeline-latency ambiguity using the tag.
- Push: rx_found=1 and (count < depth, or a pop happens in the same cycle) writes {work_id, rx_nonce}.
- Pop: tx_valid & tx_ready removes the head.
- Simultaneous push and pop:
  - Allowed at any fill level, including full and empty.
  - Count is unchanged.
  - When empty with no valid head, the push simply fills the head.
- Latency: rx_found at edge N into an empty queue -> tx_valid=1 with that nonce after edge N (visible in cycle N+1). Head is first-word-fall-through; tx_nonce/tx_work_id are stable while tx_valid=1 and tx_ready=0.
- tx_count: registered, updated at the same edge as the push/pop; range 0..depth. Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Overflow:
  - rx_found when count == depth and no pop that cycle -> entry discarded.
  - tx_overflow <= 1.
  - tx_dropped increments, saturating at 16'hFFFF with no wrap.
  - If rx_clear_overflow coincides with a drop, the drop wins: overflow=1, dropped=1.
- Flush (FLUSH_ON_WORK=1):
  - rx_new_work empties the queue: count=0, tx_valid=0 next cycle.
  - A same-cycle rx_found is enqueued after the flush with the old ID, giving count=1.
  - A same-cycle pop is ignored (already flushed).
  - Overflow state is unaffected.
- tx_valid deasserts only via pop, flush, or reset. No spurious valid occurs when empty.

Decomposition:
- Shared package (miner_pkg): GOLDEN_NONCE_WIDTH=32, DROP_CNT_WIDTH=16, and a packed entry type {work_id, nonce} parameterised by WORK_ID_WIDTH.
- One natural sub-module: sync_fifo_fwft (generic synchronous first-word-fall-through FIFO with count, full/empty). golden_nonce_queue adds the tagging, flush, and overflow accounting around it.

Test Plan:
- Reset, then rx_found with nonce 32'hDEADBEEF -> next cycle tx_valid=1, tx_nonce=DEADBEEF, tx_work_id=0, tx_count=1; tx_ready=1 -> tx_valid=0, count=0.
- tx_ready=0, 9 consecutive finds (nonces 1..9) with DEPTH_LOG2=3 -> count=8, tx_overflow=1, tx_dropped=1; drain outputs nonces 1..8 in order.
- Full queue, rx_found=0x55 with tx_ready=1 in the same cycle -> no drop, count stays 8, 0x55 emerges last.
- rx_new_work and rx_found=0xA5 in the same cycle, starting from work ID 3 -> entry tagged 3, later finds tagged 4; 16 new-work pulses from 15 wrap the ID to 15 via 0.
- FLUSH_ON_WORK=1: 3 entries queued, rx_new_work + rx_found=0x77 -> count=1, head=0x77 with old ID.
- Force tx_dropped to 16'hFFFE, 3 drops -> reads FFFF; rx_clear_overflow with a simultaneous drop -> overflow=1, dropped=1.
